// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: tone codes, the tone
// half-period table, the sequencer FSM state type and the ROM end marker.
package melody_pkg;

    localparam logic [7:0] END_MARK  = 8'h00;

    localparam logic [3:0] TONE_REST = 4'd0;
    localparam logic [3:0] TONE_C4   = 4'd1;
    localparam logic [3:0] TONE_C5   = 4'd8;
    localparam logic [3:0] TONE_C6   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_NOTE,
        ST_GAP,
        ST_DONE
    } state_t;

    // Half-period in 10 us ticks, round(50_000 / f). Code 0 (rest) maps to 0.
    function automatic logic [15:0] TONE_HP(input logic [3:0] code);
        logic [15:0] hp;
        case (code)
            4'd1:    hp = 16'd191;
            4'd2:    hp = 16'd170;
            4'd3:    hp = 16'd152;
            4'd4:    hp = 16'd143;
            4'd5:    hp = 16'd128;
            4'd6:    hp = 16'd114;
            4'd7:    hp = 16'd101;
            4'd8:    hp = 16'd96;
            4'd9:    hp = 16'd85;
            4'd10:   hp = 16'd76;
            4'd11:   hp = 16'd72;
            4'd12:   hp = 16'd64;
            4'd13:   hp = 16'd57;
            4'd14:   hp = 16'd51;
            4'd15:   hp = 16'd48;
            default: hp = 16'd0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Bus between the melody sequencer and its surroundings (key scanner,
// song control, external note ROM, speaker_play).
//   master: drives key_code, song_start, song_stop, rom_data
//   slave : the sequencer; drives rom_addr, speaker_data, play,
//           song_busy, song_done
interface melody_sequencer_if #(
    parameter int unsigned ROM_AW = 6
);
    logic [3:0]        key_code;
    logic              song_start;
    logic              song_stop;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [15:0]       speaker_data;
    logic              play;
    logic              song_busy;
    logic              song_done;

    modport master (
        output key_code, song_start, song_stop, rom_data,
        input  rom_addr, speaker_data, play, song_busy, song_done
    );

    modport slave (
        input  key_code, song_start, song_stop, rom_data,
        output rom_addr, speaker_data, play, song_busy, song_done
    );
endinterface

// File: rtl/melody_sequencer_note_timer.sv
// note_timer: loadable (units x unit length) down-counter.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        abandon any running count
//   i_load         start a count of i_units * i_unit_cyc cycles (i_units >= 1)
//   o_expired      high during the last cycle of the loaded count
module note_timer #(
    parameter int unsigned CW = 24
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [3:0]    i_units,
    input  logic [CW-1:0] i_unit_cyc,
    output logic          o_expired
);
    logic          r_active;
    logic [CW-1:0] r_cyc;
    logic [CW-1:0] r_len;
    logic [3:0]    r_units;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_active <= 1'b0;
            r_cyc    <= '0;
            r_len    <= '0;
            r_units  <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_len    <= i_unit_cyc - 1'b1;
            r_cyc    <= i_unit_cyc - 1'b1;
            r_units  <= i_units - 4'd1;
        end else if (r_active) begin
            if (r_cyc == '0) begin
                if (r_units == '0) begin
                    r_active <= 1'b0;
                end else begin
                    r_units <= r_units - 4'd1;
                    r_cyc   <= r_len;
                end
            end else begin
                r_cyc <= r_cyc - 1'b1;
            end
        end
    end

    assign o_expired = r_active && (r_cyc == '0) && (r_units == '0);
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: produces speaker_data/play for speaker_play, either
// from live keys (IDLE) or by walking a (tone, duration) song in an
// external synchronous note ROM.
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   bus (slave)       key_code, song_start, song_stop, rom_data in;
//                     rom_addr, speaker_data, play, song_busy, song_done out
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned UNIT_CYC = 12_500_000,
    parameter int unsigned GAP_CYC  = 1_000_000,
    parameter int unsigned ROM_AW   = 6
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    melody_sequencer_if.slave  bus
);
    localparam int unsigned MAXC = (UNIT_CYC > GAP_CYC) ? UNIT_CYC : GAP_CYC;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] UNIT_LEN = CW'(UNIT_CYC);
    localparam logic [CW-1:0] GAP_LEN  = CW'(GAP_CYC);

    if (UNIT_CYC == 0 || UNIT_CYC > CLK_HZ) begin : g_bad_unit
        $error("melody_sequencer: UNIT_CYC must be in 1..CLK_HZ");
    end

    state_t            r_state, w_state_nxt;
    logic [ROM_AW-1:0] r_addr,  w_addr_nxt;
    logic [15:0]       r_data,  w_data_nxt;
    logic              r_play,  w_play_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;

    logic              w_ld, w_clr, w_expired;
    logic [3:0]        w_ld_units;
    logic [CW-1:0]     w_ld_len;
    logic [3:0]        w_tone, w_dur;
    logic              w_in_song;

    assign w_tone    = bus.rom_data[7:4];
    assign w_dur     = (bus.rom_data[3:0] == 4'd0) ? 4'd1 : bus.rom_data[3:0];
    assign w_in_song = (r_state == ST_FETCH) || (r_state == ST_WAIT) ||
                       (r_state == ST_NOTE)  || (r_state == ST_GAP);

    note_timer #(.CW(CW)) u_timer (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_clear    (w_clr),
        .i_load     (w_ld),
        .i_units    (w_ld_units),
        .i_unit_cyc (w_ld_len),
        .o_expired  (w_expired)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_play  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_play  <= w_play_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Outputs are computed for the next state and registered together, so
    // play and speaker_data always change on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_play_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ld        = 1'b0;
        w_clr       = 1'b0;
        w_ld_units  = 4'd1;
        w_ld_len    = UNIT_LEN;

        case (r_state)
            ST_IDLE: begin
                if (bus.song_start && !bus.song_stop) begin
                    w_state_nxt = ST_FETCH;
                    w_addr_nxt  = '0;
                end else if (bus.key_code != TONE_REST) begin
                    w_data_nxt = TONE_HP(bus.key_code);
                    w_play_nxt = 1'b1;
                end
            end
            ST_FETCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.rom_data == END_MARK) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_addr_nxt  = '0;
                end else begin
                    w_state_nxt = ST_NOTE;
                    w_data_nxt  = TONE_HP(w_tone);
                    w_play_nxt  = (w_tone != TONE_REST);
                    w_ld        = 1'b1;
                    w_ld_units  = w_dur;
                    w_ld_len    = UNIT_LEN;
                end
            end
            ST_NOTE: begin
                w_play_nxt = r_play;
                if (w_expired) begin
                    w_play_nxt = 1'b0;
                    if (GAP_CYC != 0) begin
                        w_state_nxt = ST_GAP;
                        w_ld        = 1'b1;
                        w_ld_units  = 4'd1;
                        w_ld_len    = GAP_LEN;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_addr_nxt  = r_addr + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_expired) begin
                    w_state_nxt = ST_FETCH;
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (bus.song_start && !bus.song_stop) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Stop/restart override whatever the song states decided; stop wins.
        if (w_in_song && bus.song_stop) begin
            w_state_nxt = ST_IDLE;
            w_addr_nxt  = '0;
            w_play_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_ld        = 1'b0;
            w_clr       = 1'b1;
        end else if (w_in_song && bus.song_start) begin
            w_state_nxt = ST_FETCH;
            w_addr_nxt  = '0;
            w_play_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_ld        = 1'b0;
            w_clr       = 1'b1;
        end
    end

    assign w_busy_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_WAIT) ||
                        (w_state_nxt == ST_NOTE)  || (w_state_nxt == ST_GAP);

    assign bus.rom_addr     = r_addr;
    assign bus.speaker_data = r_data;
    assign bus.play         = r_play;
    assign bus.song_busy    = r_busy;
    assign bus.song_done    = r_done;
endmodule
